// File: rtl/gray_step_arbiter.sv
// Round-robin front end for a shared 3-bit Gray step counter: grants one requester
// at a time, steps or clears the counter, and hands the settled value back.
module gray_step_arbiter (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Req0,
  input  logic       Req1,
  input  logic [2:0] Cnt0,
  input  logic [2:0] Cnt1,
  input  logic       Clr0,
  input  logic       Clr1,
  input  logic [2:0] GrayIn,
  input  logic       OvfIn,
  output logic       CntEn,
  output logic       CntReset,
  output logic       Gnt0,
  output logic       Gnt1,
  output logic       Done0,
  output logic       Done1,
  output logic       Busy,
  output logic [2:0] Result,
  output logic       OvfOut
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_STEP  = 2'd1;
  localparam logic [1:0] S_CLEAR = 2'd2;
  localparam logic [1:0] S_WAIT  = 2'd3;

  logic [1:0] state;
  logic [3:0] rem;
  logic       owner;
  logic       last;

  logic       win;
  logic [2:0] sel_cnt;
  logic       sel_clr;

  // A tie goes to whoever did not win last time.
  always_comb begin
    win = 1'b0;
    if (Req0 && !Req1)      win = 1'b0;
    else if (Req1 && !Req0) win = 1'b1;
    else                    win = ~last;
    sel_cnt = win ? Cnt1 : Cnt0;
    sel_clr = win ? Clr1 : Clr0;
  end

  // Counter controls are pure state decodes so no request can glitch them.
  assign CntEn    = (state == S_STEP);
  assign CntReset = (state == S_CLEAR);
  assign Busy     = (state != S_IDLE);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= S_IDLE;
      rem    <= 4'd0;
      owner  <= 1'b0;
      last   <= 1'b1;
      Gnt0   <= 1'b0;
      Gnt1   <= 1'b0;
      Done0  <= 1'b0;
      Done1  <= 1'b0;
      Result <= 3'd0;
      OvfOut <= 1'b0;
    end else begin
      Gnt0  <= 1'b0;
      Gnt1  <= 1'b0;
      Done0 <= 1'b0;
      Done1 <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Req0 || Req1) begin
            owner <= win;
            last  <= win;
            Gnt0  <= ~win;
            Gnt1  <= win;
            if (sel_clr) begin
              state <= S_CLEAR;
            end else begin
              state <= S_STEP;
              rem   <= (sel_cnt == 3'd0) ? 4'd8 : {1'b0, sel_cnt};
            end
          end
        end
        S_STEP: begin
          rem <= rem - 4'd1;
          if (rem == 4'd1) state <= S_WAIT;
        end
        S_CLEAR: state <= S_WAIT;
        S_WAIT: begin
          // One idle cycle has let the counter output settle before capture.
          Result <= GrayIn;
          OvfOut <= OvfIn;
          Done0  <= ~owner;
          Done1  <= owner;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gray_step_arbiter.sv
// Bench for gray_step_arbiter: behavioural Gray counter, vector table, scoreboard
// of expected completions, and hand-written tie / reset / busy-request sequences.
module tb_gray_step_arbiter;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Req0, Req1, Clr0, Clr1;
  logic [2:0] Cnt0, Cnt1;
  logic [2:0] GrayIn;
  logic       OvfIn;
  logic       CntEn, CntReset, Gnt0, Gnt1, Done0, Done1, Busy, OvfOut;
  logic [2:0] Result;
  logic       ctr_init;

  always #5 Clk = ~Clk;

  gray_step_arbiter dut (
    .Clk(Clk), .Reset(Reset), .Req0(Req0), .Req1(Req1), .Cnt0(Cnt0), .Cnt1(Cnt1),
    .Clr0(Clr0), .Clr1(Clr1), .GrayIn(GrayIn), .OvfIn(OvfIn), .CntEn(CntEn),
    .CntReset(CntReset), .Gnt0(Gnt0), .Gnt1(Gnt1), .Done0(Done0), .Done1(Done1),
    .Busy(Busy), .Result(Result), .OvfOut(OvfOut)
  );

  // Gray sequence by index, used both by the counter model and for expectations.
  logic [2:0] gtab [8];
  initial begin
    gtab[0] = 3'b000; gtab[1] = 3'b001; gtab[2] = 3'b011; gtab[3] = 3'b010;
    gtab[4] = 3'b110; gtab[5] = 3'b111; gtab[6] = 3'b101; gtab[7] = 3'b100;
  end

  // Counter model: index register, sticky overflow on the 100 -> 000 wrap.
  logic [2:0] cidx;
  logic       covf;
  always @(posedge Clk) begin
    if (CntReset || ctr_init) begin
      cidx <= 3'd0;
      covf <= 1'b0;
    end else if (CntEn) begin
      cidx <= cidx + 3'd1;
      if (cidx == 3'd7) covf <= 1'b1;
    end
  end
  assign GrayIn = gtab[cidx];
  assign OvfIn  = covf;

  // Running totals sampled on the falling edge; the main flow takes differences.
  int cyc = 0, n_en = 0, n_rst = 0, n_busy = 0, n_g0 = 0, n_g1 = 0, n_d = 0, n_viol = 0;
  always @(negedge Clk) begin
    cyc    <= cyc + 1;
    n_en   <= n_en + int'(CntEn);
    n_rst  <= n_rst + int'(CntReset);
    n_busy <= n_busy + int'(Busy);
    n_g0   <= n_g0 + int'(Gnt0);
    n_g1   <= n_g1 + int'(Gnt1);
    n_d    <= n_d + int'(Done0) + int'(Done1);
    n_viol <= n_viol + int'(Gnt0 & Gnt1) + int'(Done0 & Done1) + int'(CntEn & CntReset);
  end

  int errors = 0, checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clk); #1;
  endtask

  typedef struct {
    logic       owner;
    logic [2:0] res;
    logic       ovf;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic       r0, r1, cl0, cl1;
    logic [2:0] c0, c1;
    logic       win;
    logic [2:0] res;
    logic       ovf;
    int         en, rst;
  } vec_t;
  vec_t vecs[8];

  task automatic wait_gnt(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      tick();
      if (Gnt0 || Gnt1) ok = 1'b1;
    end
    if (!ok) begin errors++; checks++; $display("FAIL gnt_timeout: got none expected grant"); end
  endtask

  // Waits for a Done, then pops and compares the scoreboard head.
  task automatic wait_done(input string tag, output int at);
    bit   ok;
    exp_t e;
    ok = 1'b0;
    at = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (Done0 || Done1) ok = 1'b1;
    end
    if (!ok) begin
      errors++; checks++;
      $display("FAIL %s_done_timeout: got none expected done", tag);
    end else if (sb.size() == 0) begin
      errors++; checks++;
      $display("FAIL %s_unexpected_done: got done expected none", tag);
    end else begin
      at = cyc;
      e = sb.pop_front();
      chk({tag, "_done_owner"}, int'(Done1), int'(e.owner));
      chk({tag, "_result"}, int'(Result), int'(e.res));
      chk({tag, "_ovf"}, int'(OvfOut), int'(e.ovf));
    end
  endtask

  task automatic run_vec(input int k, input vec_t v);
    int  en0, rst0, busy0, g0, v0, gc, dc;
    bit  ok;
    string tag;
    tag = $sformatf("vec%0d", k);
    en0 = n_en; rst0 = n_rst; busy0 = n_busy; g0 = n_g0 + n_g1; v0 = n_viol;
    Req0 = v.r0; Req1 = v.r1; Clr0 = v.cl0; Clr1 = v.cl1; Cnt0 = v.c0; Cnt1 = v.c1;
    sb.push_back('{owner: v.win, res: v.res, ovf: v.ovf});
    wait_gnt(ok);
    gc = cyc;
    if (ok) chk({tag, "_winner"}, int'(Gnt1), int'(v.win));
    Req0 = 1'b0; Req1 = 1'b0;
    wait_done(tag, dc);
    chk({tag, "_latency"}, dc - gc, (v.rst != 0) ? 2 : v.en + 1);
    chk({tag, "_en_cycles"}, n_en - en0, v.en);
    chk({tag, "_rst_cycles"}, n_rst - rst0, v.rst);
    chk({tag, "_busy_cycles"}, n_busy - busy0, (v.rst != 0) ? 2 : v.en + 1);
    chk({tag, "_gnt_pulses"}, n_g0 + n_g1 - g0, 1);
    chk({tag, "_exclusive"}, n_viol - v0, 0);
  endtask

  initial begin
    int  gc, dc, en0, g1_0, d0, busy_s;
    bit  ok;
    //         r0 r1 cl0 cl1 c0 c1 win res     ovf en rst
    vecs[0] = '{1, 0, 0, 0, 3, 0, 0, 3'b010, 0, 3, 0};  // basic step
    vecs[1] = '{0, 1, 0, 0, 0, 0, 1, 3'b010, 1, 8, 0};  // Cnt=0 means 8, wraps
    vecs[2] = '{1, 0, 1, 0, 0, 0, 0, 3'b000, 0, 0, 1};  // clear
    vecs[3] = '{0, 1, 0, 0, 0, 5, 1, 3'b111, 0, 5, 0};
    vecs[4] = '{1, 0, 0, 0, 4, 0, 0, 3'b001, 1, 4, 0};
    vecs[5] = '{1, 1, 0, 0, 2, 2, 1, 3'b010, 1, 2, 0};  // tie, Last=0 -> 1 wins
    vecs[6] = '{1, 1, 0, 0, 7, 0, 0, 3'b011, 1, 7, 0};  // tie, Last=1 -> 0 wins
    vecs[7] = '{1, 1, 0, 1, 5, 0, 1, 3'b000, 0, 0, 1};  // tie, winner clears

    Reset = 1'b1; ctr_init = 1'b1;
    Req0 = 0; Req1 = 0; Clr0 = 0; Clr1 = 0; Cnt0 = 0; Cnt1 = 0;
    tick(); tick();
    chk("reset_outputs", int'({CntEn, CntReset, Gnt0, Gnt1, Done0, Done1, Busy, Result, OvfOut}), 0);
    Reset = 1'b0; ctr_init = 1'b0;
    tick();
    chk("idle_busy", int'(Busy), 0);

    for (int k = 0; k < 8; k++) run_vec(k, vecs[k]);

    // Tie from fresh reset; loser keeps Req high and is served right after Done0.
    Reset = 1'b1; ctr_init = 1'b1;
    tick();
    Reset = 1'b0; ctr_init = 1'b0;
    tick();
    for (int rep = 0; rep < 2; rep++) begin
      Req0 = 1; Req1 = 1; Cnt0 = 3'd1; Cnt1 = 3'd1; Clr0 = 0; Clr1 = 0;
      sb.push_back('{owner: 1'b0, res: gtab[2*rep+1], ovf: 1'b0});
      sb.push_back('{owner: 1'b1, res: gtab[2*rep+2], ovf: 1'b0});
      wait_gnt(ok);
      if (ok) chk($sformatf("tie%0d_first_gnt0", rep), int'({Gnt0, Gnt1}), 2);
      Req0 = 0;
      wait_done($sformatf("tie%0d_a", rep), dc);
      wait_gnt(ok);
      if (ok) chk($sformatf("tie%0d_second_gnt1", rep), int'({Gnt0, Gnt1}), 1);
      chk($sformatf("tie%0d_gnt1_after_done0", rep), cyc - dc, 1);
      Req1 = 0;
      wait_done($sformatf("tie%0d_b", rep), dc);
    end

    // Reset in the 3rd STEP cycle: counter keeps 3 steps from index 4.
    en0 = n_en; d0 = n_d;
    Req0 = 1; Cnt0 = 3'd5;
    wait_gnt(ok);
    Req0 = 0;
    tick();
    tick();
    chk("rst_mid_in_step", int'(CntEn), 1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("rst_mid_busy_en", int'({Busy, CntEn, Done0}), 0);
    chk("rst_mid_result", int'(Result), 0);
    for (int i = 0; i < 4; i++) tick();
    chk("rst_mid_no_done", n_d - d0, 0);
    chk("rst_mid_en_cycles", n_en - en0, 3);
    chk("rst_mid_counter", int'(GrayIn), int'(gtab[7]));

    // Req1 pulse while busy must be ignored.
    en0 = n_en; g1_0 = n_g1;
    Req0 = 1; Cnt0 = 3'd4;
    sb.push_back('{owner: 1'b0, res: gtab[3], ovf: 1'b1});
    wait_gnt(ok);
    gc = cyc;
    Req0 = 0;
    tick();
    Req1 = 1; Cnt1 = 3'd2;
    tick();
    Req1 = 0;
    busy_s = int'(Busy);
    chk("busy_req_still_busy", busy_s, 1);
    wait_done("busy_req", dc);
    chk("busy_req_latency", dc - gc, 5);
    chk("busy_req_no_gnt1", n_g1 - g1_0, 0);
    chk("busy_req_en_cycles", n_en - en0, 4);
    for (int i = 0; i < 3; i++) tick();
    chk("busy_req_stays_idle", int'({Busy, Gnt1}), 0);
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
